// File: rtl/usb_rx_deserializer.sv
// Full-speed USB receive front end: line decode, NRZI, SYNC detect, bit destuff, LSB-first bytes, EOP check.
// Define USB_RX_BABBLE_CHECK_EN to abort packets longer than MAX_BYTES with error code 6.
//
// state   | meaning
// IDLE    | bus idle, waiting for the first K of SYNC
// SYNC    | counting decoded zeros until the terminating one
// DATA    | destuffing and assembling bytes
// EOP     | counting SE0 bit times, waiting for the closing J
// ABORT   | error reported, waiting for SE0->J or 8 idle J samples
module usb_rx_deserializer #(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int EOP_MAX_SE0    = 3,
    parameter int MAX_BYTES      = 1026
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       sample_valid,
    input  logic       dp,
    input  logic       dm,
    output logic       byte_valid,
    output logic [7:0] data_out,
    output logic       packet_done,
    output logic       rx_active,
    output logic       rx_error,
    output logic [2:0] err_code
);

`ifdef USB_RX_BABBLE_CHECK_EN
    localparam bit BABBLE_EN  = 1'b1;
    localparam int BYTE_CNT_W = 11;
`else
    localparam bit BABBLE_EN  = 1'b0;
    localparam int BYTE_CNT_W = 1;
`endif
    localparam int SE0_CNT_W = $clog2(EOP_MAX_SE0 + 2);

    localparam logic [2:0] ERR_SYNC   = 3'd1;
    localparam logic [2:0] ERR_STUFF  = 3'd2;
    localparam logic [2:0] ERR_ALIGN  = 3'd3;
    localparam logic [2:0] ERR_EOP    = 3'd4;
    localparam logic [2:0] ERR_SE1    = 3'd5;
    localparam logic [2:0] ERR_BABBLE = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP,
        S_ABORT
    } state_t;

    state_t                 state, state_nxt;
    logic                   prev_j, prev_j_nxt;
    logic [2:0]             zero_cnt, zero_cnt_nxt;
    logic [2:0]             ones_cnt, ones_cnt_nxt;
    logic [2:0]             bit_cnt, bit_cnt_nxt;
    logic [BYTE_CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
    logic [7:0]             shift_reg, shift_nxt;
    logic [SE0_CNT_W-1:0]   se0_cnt, se0_cnt_nxt;
    logic [2:0]             abort_j, abort_j_nxt;
    logic                   abort_se0, abort_se0_nxt;
    logic                   byte_valid_nxt, packet_done_nxt, rx_active_nxt, rx_error_nxt;
    logic [7:0]             data_out_nxt;
    logic [2:0]             err_code_nxt;
    logic                   abort_req;
    logic [2:0]             abort_code;

    logic line_j, line_k, line_se0, line_se1, nrzi_bit, babble_hit;

    assign line_j   =  dp & ~dm;
    assign line_k   = ~dp &  dm;
    assign line_se0 = ~dp & ~dm;
    assign line_se1 =  dp &  dm;
    // prev_j holds dp of the last J/K sample, so equal dp means no transition
    assign nrzi_bit   = (dp == prev_j);
    assign babble_hit = BABBLE_EN && (int'(byte_cnt) == MAX_BYTES);

    always_comb begin
        state_nxt       = state;
        prev_j_nxt      = prev_j;
        zero_cnt_nxt    = zero_cnt;
        ones_cnt_nxt    = ones_cnt;
        bit_cnt_nxt     = bit_cnt;
        byte_cnt_nxt    = byte_cnt;
        shift_nxt       = shift_reg;
        se0_cnt_nxt     = se0_cnt;
        abort_j_nxt     = abort_j;
        abort_se0_nxt   = abort_se0;
        data_out_nxt    = data_out;
        rx_active_nxt   = rx_active;
        err_code_nxt    = err_code;
        byte_valid_nxt  = 1'b0;
        packet_done_nxt = 1'b0;
        rx_error_nxt    = 1'b0;
        abort_req       = 1'b0;
        abort_code      = 3'd0;

        if (sample_valid) begin
            if (line_j || line_k) begin
                prev_j_nxt = line_j;
            end

            case (state)
                S_IDLE: begin
                    if (line_k) begin
                        state_nxt    = S_SYNC;
                        zero_cnt_nxt = 3'd1;
                    end
                end

                S_SYNC: begin
                    if (line_se0) begin
                        state_nxt = S_IDLE;
                    end else if (line_se1) begin
                        abort_req  = 1'b1;
                        abort_code = ERR_SE1;
                    end else if (!nrzi_bit) begin
                        if (zero_cnt != 3'd7) begin
                            zero_cnt_nxt = zero_cnt + 3'd1;
                        end
                    end else if (int'(zero_cnt) >= SYNC_MIN_ZEROS) begin
                        state_nxt     = S_DATA;
                        rx_active_nxt = 1'b1;
                        bit_cnt_nxt   = '0;
                        ones_cnt_nxt  = '0;
                        byte_cnt_nxt  = '0;
                    end else begin
                        abort_req  = 1'b1;
                        abort_code = ERR_SYNC;
                    end
                end

                S_DATA: begin
                    if (line_se0) begin
                        state_nxt   = S_EOP;
                        se0_cnt_nxt = SE0_CNT_W'(1);
                    end else if (line_se1) begin
                        abort_req  = 1'b1;
                        abort_code = ERR_SE1;
                    end else if (ones_cnt == 3'd6) begin
                        if (nrzi_bit) begin
                            abort_req  = 1'b1;
                            abort_code = ERR_STUFF;
                        end else begin
                            ones_cnt_nxt = '0;
                        end
                    end else begin
                        shift_nxt    = {nrzi_bit, shift_reg[7:1]};
                        ones_cnt_nxt = nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_nxt = '0;
                            if (babble_hit) begin
                                abort_req  = 1'b1;
                                abort_code = ERR_BABBLE;
                            end else begin
                                byte_valid_nxt = 1'b1;
                                data_out_nxt   = {nrzi_bit, shift_reg[7:1]};
                                if (BABBLE_EN) begin
                                    byte_cnt_nxt = byte_cnt + BYTE_CNT_W'(1);
                                end else begin
                                    byte_cnt_nxt = '1;
                                end
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end

                S_EOP: begin
                    if (line_se0) begin
                        if (int'(se0_cnt) >= EOP_MAX_SE0) begin
                            abort_req  = 1'b1;
                            abort_code = ERR_EOP;
                        end else begin
                            se0_cnt_nxt = se0_cnt + SE0_CNT_W'(1);
                        end
                    end else if (line_j) begin
                        state_nxt     = S_IDLE;
                        rx_active_nxt = 1'b0;
                        if (bit_cnt != 3'd0 || byte_cnt == '0) begin
                            rx_error_nxt = 1'b1;
                            err_code_nxt = ERR_ALIGN;
                        end else begin
                            packet_done_nxt = 1'b1;
                        end
                    end else begin
                        abort_req  = 1'b1;
                        abort_code = ERR_EOP;
                    end
                end

                S_ABORT: begin
                    if (line_j) begin
                        abort_se0_nxt = 1'b0;
                        if (abort_se0 || abort_j == 3'd7) begin
                            state_nxt   = S_IDLE;
                            abort_j_nxt = '0;
                        end else begin
                            abort_j_nxt = abort_j + 3'd1;
                        end
                    end else begin
                        abort_j_nxt   = '0;
                        abort_se0_nxt = line_se0;
                    end
                end

                default: state_nxt = S_IDLE;
            endcase

            // the sample that triggered the abort already counts toward the exit condition
            if (abort_req) begin
                state_nxt     = S_ABORT;
                rx_error_nxt  = 1'b1;
                err_code_nxt  = abort_code;
                rx_active_nxt = 1'b0;
                abort_se0_nxt = line_se0;
                abort_j_nxt   = line_j ? 3'd1 : 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nRST) begin
            state       <= S_IDLE;
            prev_j      <= 1'b1;
            zero_cnt    <= '0;
            ones_cnt    <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            shift_reg   <= '0;
            se0_cnt     <= '0;
            abort_j     <= '0;
            abort_se0   <= 1'b0;
            byte_valid  <= 1'b0;
            data_out    <= '0;
            packet_done <= 1'b0;
            rx_active   <= 1'b0;
            rx_error    <= 1'b0;
            err_code    <= '0;
        end else begin
            state       <= state_nxt;
            prev_j      <= prev_j_nxt;
            zero_cnt    <= zero_cnt_nxt;
            ones_cnt    <= ones_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            byte_cnt    <= byte_cnt_nxt;
            shift_reg   <= shift_nxt;
            se0_cnt     <= se0_cnt_nxt;
            abort_j     <= abort_j_nxt;
            abort_se0   <= abort_se0_nxt;
            byte_valid  <= byte_valid_nxt;
            data_out    <= data_out_nxt;
            packet_done <= packet_done_nxt;
            rx_active   <= rx_active_nxt;
            rx_error    <= rx_error_nxt;
            err_code    <= err_code_nxt;
        end
    end

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Bench for usb_rx_deserializer: packet-level encoder (stuffing + NRZI) with an event scoreboard.
// Covers the table of directed packets, a mid-packet reset, and randomized clean/truncated packets.
module tb_usb_rx_deserializer;

    logic       clk = 1'b0;
    logic       nRST;
    logic       sample_valid;
    logic       dp;
    logic       dm;
    logic       byte_valid;
    logic [7:0] data_out;
    logic       packet_done;
    logic       rx_active;
    logic       rx_error;
    logic [2:0] err_code;

    always #5 clk = ~clk;

    usb_rx_deserializer #(
        .SYNC_MIN_ZEROS(5),
        .EOP_MAX_SE0   (3),
        .MAX_BYTES     (4)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .sample_valid(sample_valid),
        .dp          (dp),
        .dm          (dm),
        .byte_valid  (byte_valid),
        .data_out    (data_out),
        .packet_done (packet_done),
        .rx_active   (rx_active),
        .rx_error    (rx_error),
        .err_code    (err_code)
    );

    localparam int L_J = 0, L_K = 1, L_SE0 = 2, L_SE1 = 3;
    localparam logic [2:0] EV_BYTE = 3'd1, EV_DONE = 3'd2, EV_ERR = 3'd3;

    typedef struct {
        string       name;
        int          sync_zeros;
        logic [63:0] bits;
        int          nbits;
        bit          stuff;
        int          tail;       // 0 = SE0 x se0_len then J, 1 = SE0 K SE0 J, 2 = SE1 SE0 J
        int          se0_len;
        int          exp_nbytes;
        logic [63:0] exp_bytes;
        bit          exp_done;
        int          exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] ev_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          last_err = 0;
    int          gap_max = 2;
    bit          tx_j = 1'b1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (byte_valid)  ev_q.push_back({EV_BYTE, data_out});
        if (packet_done) begin
            ev_q.push_back({EV_DONE, 8'h00});
            check("done_vs_byte_valid", {31'd0, byte_valid}, 32'd0);
        end
        if (rx_error)    ev_q.push_back({EV_ERR, 5'd0, err_code});
    end

    task automatic strobe(int l);
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        case (l)
            L_J:     {dp, dm} = 2'b10;
            L_K:     {dp, dm} = 2'b01;
            L_SE0:   {dp, dm} = 2'b00;
            default: {dp, dm} = 2'b11;
        endcase
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic send_bit(bit b);
        if (!b) tx_j = !tx_j;
        strobe(tx_j ? L_J : L_K);
    endtask

    task automatic send_data(logic [63:0] bits, int n, bit stuff);
        int ones = 0;
        for (int i = 0; i < n; i++) begin
            send_bit(bits[i]);
            ones = bits[i] ? ones + 1 : 0;
            if (stuff && ones == 6) begin
                send_bit(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic add_vec(string name, int zeros, logic [63:0] bits, int nbits, bit stuff, int tail,
                           int se0_len, int exp_nbytes, logic [63:0] exp_bytes, bit exp_done, int exp_err);
        vec_t v;
        v.name = name; v.sync_zeros = zeros; v.bits = bits; v.nbits = nbits; v.stuff = stuff;
        v.tail = tail; v.se0_len = se0_len; v.exp_nbytes = exp_nbytes; v.exp_bytes = exp_bytes;
        v.exp_done = exp_done; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic run_vector(vec_t v);
        logic [10:0] exp_q[$];
        int          n;
        ev_q.delete();
        tx_j = 1'b1;
        strobe(L_J);
        strobe(L_J);
        for (int i = 0; i < v.sync_zeros; i++) send_bit(1'b0);
        check({v.name, ":active_before_sync_end"}, {31'd0, rx_active}, 32'd0);
        send_bit(1'b1);
        check({v.name, ":active_after_sync"}, {31'd0, rx_active}, (v.sync_zeros >= 5) ? 32'd1 : 32'd0);
        send_data(v.bits, v.nbits, v.stuff);
        case (v.tail)
            1: begin strobe(L_SE0); strobe(L_K); strobe(L_SE0); end
            2: begin strobe(L_SE1); strobe(L_SE0); end
            default: for (int i = 0; i < v.se0_len; i++) strobe(L_SE0);
        endcase
        strobe(L_J);
        tx_j = 1'b1;
        check({v.name, ":packet_done_after_j"}, {31'd0, packet_done}, {31'd0, v.exp_done});
        check({v.name, ":active_after_j"}, {31'd0, rx_active}, 32'd0);
        strobe(L_J);
        strobe(L_J);
        repeat (3) @(negedge clk);

        for (int i = 0; i < v.exp_nbytes; i++) exp_q.push_back({EV_BYTE, v.exp_bytes[8*i +: 8]});
        if (v.exp_done) exp_q.push_back({EV_DONE, 8'h00});
        if (v.exp_err != 0) begin
            exp_q.push_back({EV_ERR, 5'd0, 3'(v.exp_err)});
            last_err = v.exp_err;
        end
        check({v.name, ":event_count"}, 32'(ev_q.size()), 32'(exp_q.size()));
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({v.name, ":event"}, {21'd0, ev_q[i]}, {21'd0, exp_q[i]});
        check({v.name, ":err_code_hold"}, {29'd0, err_code}, 32'(last_err));
    endtask

    initial begin
        vec_t        rv;
        int          nbytes, extra;
        logic [63:0] rbits;

        nRST = 1'b1; sample_valid = 1'b0; dp = 1'b1; dm = 1'b0;

        add_vec("ack",        7, 64'hD2,       8,  1, 0, 2, 1, 64'hD2,   1, 0);
        add_vec("ff_ff",      7, 64'hFFFF,     16, 1, 0, 2, 2, 64'hFFFF, 1, 0);
        add_vec("stuff_err",  7, 64'h7F,       7,  0, 0, 2, 0, 64'h0,    0, 2);
        add_vec("after_err",  7, 64'h4B,       8,  1, 0, 2, 1, 64'h4B,   1, 0);
        add_vec("partial",    7, 64'h35A,      12, 1, 0, 2, 1, 64'h5A,   0, 3);
        add_vec("empty",      7, 64'h0,        0,  1, 0, 2, 0, 64'h0,    0, 3);
        add_vec("sync_short", 4, 64'h0,        0,  1, 0, 2, 0, 64'h0,    0, 1);
        add_vec("sync_min",   5, 64'hE1,       8,  1, 0, 1, 1, 64'hE1,   1, 0);
        add_vec("se0_long",   7, 64'hA5,       8,  1, 0, 4, 1, 64'hA5,   0, 4);
        add_vec("eop_k",      7, 64'h11,       8,  1, 1, 1, 1, 64'h11,   0, 4);
        add_vec("se1_data",   7, 64'h22,       8,  1, 2, 1, 1, 64'h22,   0, 5);
`ifdef USB_RX_BABBLE_CHECK_EN
        add_vec("five_bytes", 7, 64'h0504030201, 40, 1, 0, 2, 4, 64'h04030201,   0, 6);
`else
        add_vec("five_bytes", 7, 64'h0504030201, 40, 1, 0, 2, 5, 64'h0504030201, 1, 0);
`endif

        repeat (3) @(negedge clk);
        check("reset:byte_valid",  {31'd0, byte_valid},  32'd0);
        check("reset:data_out",    {24'd0, data_out},    32'd0);
        check("reset:packet_done", {31'd0, packet_done}, 32'd0);
        check("reset:rx_active",   {31'd0, rx_active},   32'd0);
        check("reset:rx_error",    {31'd0, rx_error},    32'd0);
        check("reset:err_code",    {29'd0, err_code},    32'd0);
        nRST = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vector(vecs[i]);

        // reset in the middle of a byte
        ev_q.delete();
        tx_j = 1'b1;
        strobe(L_J);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
        send_data(64'h0C, 4, 1'b1);
        check("midrst:active_before", {31'd0, rx_active}, 32'd1);
        nRST = 1'b1;
        @(negedge clk);
        nRST = 1'b0;
        check("midrst:byte_valid",  {31'd0, byte_valid},  32'd0);
        check("midrst:data_out",    {24'd0, data_out},    32'd0);
        check("midrst:packet_done", {31'd0, packet_done}, 32'd0);
        check("midrst:rx_active",   {31'd0, rx_active},   32'd0);
        check("midrst:rx_error",    {31'd0, rx_error},    32'd0);
        check("midrst:err_code",    {29'd0, err_code},    32'd0);
        repeat (3) @(negedge clk);
        check("midrst:no_events", 32'(ev_q.size()), 32'd0);
        last_err = 0;
        rv.name = "after_rst"; rv.sync_zeros = 7; rv.bits = 64'h3C; rv.nbits = 8; rv.stuff = 1;
        rv.tail = 0; rv.se0_len = 2; rv.exp_nbytes = 1; rv.exp_bytes = 64'h3C; rv.exp_done = 1; rv.exp_err = 0;
        run_vector(rv);

        // randomized clean and truncated packets
        for (int p = 0; p < 40; p++) begin
            nbytes = $urandom_range(6, 1);
            extra  = ($urandom_range(3, 0) == 0) ? $urandom_range(7, 1) : 0;
            rbits  = {$urandom, $urandom};
            rv.name       = $sformatf("rand%0d", p);
            rv.sync_zeros = $urandom_range(7, 5);
            rv.bits       = rbits;
            rv.nbits      = 8 * nbytes + extra;
            rv.stuff      = 1'b1;
            rv.tail       = 0;
            rv.se0_len    = $urandom_range(3, 1);
            rv.exp_bytes  = rbits;
`ifdef USB_RX_BABBLE_CHECK_EN
            if (nbytes > 4) begin
                rv.exp_nbytes = 4; rv.exp_done = 0; rv.exp_err = 6;
            end else
`endif
            begin
                rv.exp_nbytes = nbytes;
                rv.exp_done   = (extra == 0);
                rv.exp_err    = (extra == 0) ? 0 : 3;
            end
            run_vector(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
